// File: rtl/nif_pkg.sv
// nif_pkg -- shared definitions for the network interface.
//   Flit layout (MSB..LSB): {dest[node_w], src[node_w], payload[32]}.
//   Provides field offset helpers, a flit struct for the default 4-bit
//   node address, and the LWNET read-FSM state encoding.
package nif_pkg;

  localparam int NIF_PAYLOAD_W = 32;
  localparam int NIF_DEFAULT_NODE_W = 4;

  typedef struct packed {
    logic [NIF_DEFAULT_NODE_W-1:0] dest;
    logic [NIF_DEFAULT_NODE_W-1:0] src;
    logic [NIF_PAYLOAD_W-1:0]      payload;
  } nif_flit_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } nif_rd_state_e;

  function automatic int nif_flit_w(input int node_w);
    return 2 * node_w + NIF_PAYLOAD_W;
  endfunction

  function automatic int nif_src_lsb(input int node_w);
    return NIF_PAYLOAD_W + 0 * node_w;
  endfunction

  function automatic int nif_dest_lsb(input int node_w);
    return NIF_PAYLOAD_W + node_w;
  endfunction

endpackage

// File: rtl/nif_sync_fifo.sv
// nif_sync_fifo -- single-clock FIFO, DEPTH a power of two.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write request/data; ignored while full
//   pop        : read request; ignored while empty
//   dout       : head entry (combinational, valid while !empty)
//   full/empty : status
//   count      : occupancy 0..DEPTH (one bit wider than the pointers)
module nif_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/network_interface.sv
// network_interface -- node-side responder for SWNET/LWNET.
//   SWNET (cpu_write) packs {cpu_dest, NODE_ID, cpu_write_data} into the TX
//   FIFO towards the router; LWNET (cpu_read) pops the RX FIFO and returns
//   the payload on cpu_read_data. cpu_busy stalls the pipeline.
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   cpu_write/read    SWNET / LWNET in MEM stage
//   cpu_dest          destination node of a SWNET
//   cpu_write_data    SWNET payload
//   cpu_read_data     LWNET payload, valid when cpu_read && !cpu_busy
//   cpu_busy          stall request
//   tx_flit/valid/ready  outbound flit channel
//   rx_flit/valid/ready  inbound flit channel
//   misroute_err      sticky: received a flit not addressed to this node
//   rx_irq            RX occupancy >= IRQ_THRESHOLD (only with NIF_IRQ_EN)
//   dbg_rd_state      read-FSM state
//   dbg_tx_count, dbg_rx_count  FIFO occupancies
//   dbg_last_src      source node of the most recent LWNET payload
// Handshake: a flit moves on a rising CLK edge where valid && ready; the
//   sender holds the flit stable while valid && !ready.
// Build option: define NIF_IRQ_EN to generate the registered rx_irq
//   comparator; otherwise rx_irq is tied low.
module network_interface
  import nif_pkg::*;
#(
  parameter int NODE_ID       = 0,
  parameter int NODE_W        = 4,
  parameter int TX_DEPTH      = 4,
  parameter int RX_DEPTH      = 4,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         cpu_write,
  input  logic                         cpu_read,
  input  logic [NODE_W-1:0]            cpu_dest,
  input  logic [31:0]                  cpu_write_data,
  output logic [31:0]                  cpu_read_data,
  output logic                         cpu_busy,
  output logic [2*NODE_W+31:0]         tx_flit,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  input  logic [2*NODE_W+31:0]         rx_flit,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         misroute_err,
  output logic                         rx_irq,
  output nif_rd_state_e                dbg_rd_state,
  output logic [$clog2(TX_DEPTH):0]    dbg_tx_count,
  output logic [$clog2(RX_DEPTH):0]    dbg_rx_count,
  output logic [NODE_W-1:0]            dbg_last_src
);

  localparam int FLIT_W   = nif_flit_w(NODE_W);
  localparam int SRC_LSB  = nif_src_lsb(NODE_W);
  localparam int DEST_LSB = nif_dest_lsb(NODE_W);
  localparam int RXE_W    = NODE_W + NIF_PAYLOAD_W;  // RX keeps {src, payload}
  localparam int RX_AW    = $clog2(RX_DEPTH);
  localparam logic [NODE_W-1:0] MY_ID = NODE_W'(NODE_ID);

  // Elaboration-time parameter sanity checks.
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("TX_DEPTH must be a power of two >= 2");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
    $error("RX_DEPTH must be a power of two >= 2");
  end
  if (IRQ_THRESHOLD < 1 || IRQ_THRESHOLD > RX_DEPTH) begin : g_bad_irq
    $error("IRQ_THRESHOLD must be in 1..RX_DEPTH");
  end

  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic              rx_fire, rx_for_me;
  logic [RXE_W-1:0]  rx_head;
  logic [RX_AW:0]    rx_count;
  logic              write_stall, read_stall;
  nif_rd_state_e     rd_state, rd_state_next;

  // ---------------- TX path ----------------
  // A full FIFO stalls the write even if the router pops this same cycle;
  // the push then lands on the following edge.
  assign tx_push     = cpu_write && !tx_full;
  assign write_stall = cpu_write && tx_full;
  assign tx_valid    = !tx_empty;
  assign tx_pop      = tx_valid && tx_ready;

  nif_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   ({cpu_dest, MY_ID, cpu_write_data}),
    .dout  (tx_flit),
    .full  (tx_full),
    .empty (tx_empty),
    .count (dbg_tx_count)
  );

  // ---------------- RX path ----------------
  assign rx_ready  = !rx_full && !RESET;
  assign rx_fire   = rx_valid && rx_ready;
  assign rx_for_me = (rx_flit[DEST_LSB +: NODE_W] == MY_ID);
  assign rx_push   = rx_fire && rx_for_me;

  nif_sync_fifo #(.WIDTH(RXE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_flit[RXE_W-1:0]),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign dbg_rx_count = rx_count;

  // Misaddressed flits are consumed (ready is honoured) but discarded.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                      misroute_err <= 1'b0;
    else if (rx_fire && !rx_for_me) misroute_err <= 1'b1;
  end

  // ---------------- LWNET read FSM ----------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rd_state <= RD_IDLE;
    else       rd_state <= rd_state_next;
  end

  always_comb begin
    rd_state_next = rd_state;
    read_stall    = 1'b0;
    rx_pop        = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (cpu_read) begin
          read_stall = 1'b1;
          if (!rx_empty) begin
            rx_pop        = 1'b1;
            rd_state_next = RD_DONE;
          end else begin
            rd_state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // The pipeline flushing the load drops cpu_read; abandon quietly.
        if (!cpu_read) begin
          rd_state_next = RD_IDLE;
        end else begin
          read_stall = 1'b1;
          if (!rx_empty) begin
            rx_pop        = 1'b1;
            rd_state_next = RD_DONE;
          end
        end
      end
      RD_DONE: rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cpu_read_data <= '0;
      dbg_last_src  <= '0;
    end else if (rx_pop) begin
      cpu_read_data <= rx_head[NIF_PAYLOAD_W-1:0];
      dbg_last_src  <= rx_head[SRC_LSB +: NODE_W];
    end
  end

  assign dbg_rd_state = rd_state;
  assign cpu_busy     = !RESET && (write_stall || read_stall);

  // ---------------- RX interrupt ----------------
`ifdef NIF_IRQ_EN
  localparam logic [RX_AW:0] IRQ_THR = (RX_AW+1)'(IRQ_THRESHOLD);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rx_irq <= 1'b0;
    else       rx_irq <= (rx_count >= IRQ_THR);
  end
`else
  assign rx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_network_interface.sv
// tb_network_interface -- directed self-checking bench for network_interface
// (NODE_ID=2, 4-bit addresses, 4-deep FIFOs, IRQ_THRESHOLD=2).
module tb_network_interface;
  import nif_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_write, cpu_read;
  logic [3:0]  cpu_dest;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        cpu_busy;
  logic [39:0] tx_flit;
  logic        tx_valid, tx_ready;
  logic [39:0] rx_flit;
  logic        rx_valid, rx_ready;
  logic        misroute_err, rx_irq;
  nif_rd_state_e dbg_rd_state;
  logic [2:0]  dbg_tx_count, dbg_rx_count;
  logic [3:0]  dbg_last_src;

  int n_assert = 0;
  int n_fail   = 0;

  network_interface #(
    .NODE_ID(2), .NODE_W(4), .TX_DEPTH(4), .RX_DEPTH(4), .IRQ_THRESHOLD(2)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_write(cpu_write), .cpu_read(cpu_read), .cpu_dest(cpu_dest),
    .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .cpu_busy(cpu_busy),
    .tx_flit(tx_flit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_flit(rx_flit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .misroute_err(misroute_err), .rx_irq(rx_irq),
    .dbg_rd_state(dbg_rd_state), .dbg_tx_count(dbg_tx_count),
    .dbg_rx_count(dbg_rx_count), .dbg_last_src(dbg_last_src)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mk_flit(input logic [3:0] d, input logic [3:0] s,
                                          input logic [31:0] p);
    return {d, s, p};
  endfunction

  logic [39:0] exp_flit [5];
  int          busy_cycles;
  logic        exp_irq;

  // ---------------- directed sequence ----------------
  initial begin
    RESET = 1'b1; cpu_write = 0; cpu_read = 0; cpu_dest = '0; cpu_write_data = '0;
    tx_ready = 0; rx_flit = '0; rx_valid = 0;
    tick(); tick();
    settle();
    chk("reset_busy",      64'(cpu_busy), 64'd0);
    chk("reset_tx_valid",  64'(tx_valid), 64'd0);
    chk("reset_irq",       64'(rx_irq), 64'd0);
    chk("reset_rdata",     64'(cpu_read_data), 64'd0);
    chk("reset_misroute",  64'(misroute_err), 64'd0);
    chk("reset_state",     64'(dbg_rd_state), 64'(RD_IDLE));
    RESET = 1'b0;
    settle();
    chk("rx_ready_after_reset", 64'(rx_ready), 64'd1);

    // 1. single SWNET with router ready
    tick();
    tx_ready = 1; cpu_write = 1; cpu_dest = 4'd5; cpu_write_data = 32'hDEADBEEF;
    settle();
    chk("t1_busy", 64'(cpu_busy), 64'd0);
    chk("t1_tx_valid_pre", 64'(tx_valid), 64'd0);
    tick();
    cpu_write = 0;
    settle();
    chk("t1_tx_valid", 64'(tx_valid), 64'd1);
    chk("t1_tx_flit", 64'(tx_flit), 64'h52DEADBEEF);
    tick();
    chk("t1_tx_valid_drop", 64'(tx_valid), 64'd0);

    // 2. TX backpressure: 4 fill, 5th stalls
    tx_ready = 0;
    for (int i = 0; i < 5; i++)
      exp_flit[i] = mk_flit(4'(i + 1), 4'd2, 32'h100 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      cpu_write = 1; cpu_dest = 4'(i + 1); cpu_write_data = 32'h100 + 32'(i);
      settle();
      chk("t2_fill_busy", 64'(cpu_busy), 64'd0);
      tick();
    end
    cpu_dest = 4'd5; cpu_write_data = 32'h104;
    settle();
    chk("t2_full_busy", 64'(cpu_busy), 64'd1);
    tick();
    chk("t2_count_full", 64'(dbg_tx_count), 64'd4);
    chk("t2_still_busy", 64'(cpu_busy), 64'd1);
    tx_ready = 1;
    settle();
    chk("t2_busy_with_pop", 64'(cpu_busy), 64'd1);
    chk("t2_flit0", 64'(tx_flit), 64'(exp_flit[0]));
    tick();
    chk("t2_busy_released", 64'(cpu_busy), 64'd0);
    chk("t2_flit1", 64'(tx_flit), 64'(exp_flit[1]));
    tick();
    cpu_write = 0;
    for (int i = 2; i < 5; i++) begin
      settle();
      chk("t2_flit_order", 64'(tx_flit), 64'(exp_flit[i]));
      tick();
    end
    chk("t2_drained", 64'(tx_valid), 64'd0);

    // 3. LWNET on empty RX, flit arrives while waiting
    busy_cycles = 0;
    cpu_read = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin rx_flit = mk_flit(4'd2, 4'd7, 32'h1234); rx_valid = 1; end
      if (c == 3) rx_valid = 0;
      settle();
      if (!cpu_busy) break;
      busy_cycles++;
      tick();
    end
    chk("t3_busy_cycles", 64'(busy_cycles), 64'd4);
    chk("t3_rdata", 64'(cpu_read_data), 64'h1234);
    chk("t3_src", 64'(dbg_last_src), 64'd7);
    chk("t3_state_done", 64'(dbg_rd_state), 64'(RD_DONE));
    cpu_read = 0;
    tick();
    chk("t3_state_idle", 64'(dbg_rd_state), 64'(RD_IDLE));
    chk("t3_rdata_held", 64'(cpu_read_data), 64'h1234);

    // minimum-latency LWNET with data already buffered
    rx_flit = mk_flit(4'd2, 4'd9, 32'hCAFE0001); rx_valid = 1;
    tick();
    rx_valid = 0; cpu_read = 1;
    settle();
    chk("lat_busy_first", 64'(cpu_busy), 64'd1);
    tick();
    chk("lat_busy_second", 64'(cpu_busy), 64'd0);
    chk("lat_rdata", 64'(cpu_read_data), 64'hCAFE0001);
    cpu_read = 0;
    tick();

    // 4. misrouted flit
    rx_flit = mk_flit(4'd3, 4'd1, 32'h0BAD); rx_valid = 1;
    settle();
    chk("t4_rx_ready", 64'(rx_ready), 64'd1);
    tick();
    rx_valid = 0;
    tick();
    chk("t4_misroute", 64'(misroute_err), 64'd1);
    chk("t4_rx_empty", 64'(dbg_rx_count), 64'd0);

    // RX fill to full (and rx_irq threshold when enabled)
    for (int i = 0; i < 4; i++) begin
      rx_flit = mk_flit(4'd2, 4'(i), 32'hA0 + 32'(i)); rx_valid = 1;
      tick();
`ifdef NIF_IRQ_EN
      exp_irq = (i >= 2);
`else
      exp_irq = 1'b0;
`endif
      chk("fill_irq", 64'(rx_irq), 64'(exp_irq));
    end
    rx_flit = mk_flit(4'd2, 4'd15, 32'hFFFF);
    settle();
    chk("rx_full_ready", 64'(rx_ready), 64'd0);
    tick();
    rx_valid = 0;
    chk("rx_full_count", 64'(dbg_rx_count), 64'd4);
    chk("misroute_sticky", 64'(misroute_err), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cpu_read = 1;
      tick();
      chk("drain_busy", 64'(cpu_busy), 64'd0);
      chk("drain_data", 64'(cpu_read_data), 64'hA0 + 64'(i));
      chk("drain_src", 64'(dbg_last_src), 64'(i));
      cpu_read = 0;
      tick();
`ifdef NIF_IRQ_EN
      exp_irq = (i <= 1);
`else
      exp_irq = 1'b0;
`endif
      chk("drain_irq", 64'(rx_irq), 64'(exp_irq));
    end
    chk("drain_empty", 64'(dbg_rx_count), 64'd0);

    // LWNET flushed while waiting: no pop of a later flit
    cpu_read = 1;
    tick();
    chk("flush_wait", 64'(dbg_rd_state), 64'(RD_WAIT));
    cpu_read = 0;
    settle();
    chk("flush_busy", 64'(cpu_busy), 64'd0);
    tick();
    chk("flush_idle", 64'(dbg_rd_state), 64'(RD_IDLE));
    rx_flit = mk_flit(4'd2, 4'd4, 32'h5555); rx_valid = 1;
    tick();
    rx_valid = 0;
    tick();
    chk("flush_no_pop", 64'(dbg_rx_count), 64'd1);

    // 5. reset in the middle of RD_WAIT with TX flits queued
    tx_ready = 0; cpu_read = 1;
    tick();  // RX non-empty: this read completes
    cpu_read = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      cpu_write = 1; cpu_dest = 4'(i); cpu_write_data = 32'(i);
      tick();
    end
    cpu_write = 0; cpu_read = 1;
    tick(); tick();
    chk("t5_pre_state", 64'(dbg_rd_state), 64'(RD_WAIT));
    chk("t5_pre_tx_valid", 64'(tx_valid), 64'd1);
    RESET = 1;
    settle();
    chk("t5_tx_valid", 64'(tx_valid), 64'd0);
    chk("t5_busy", 64'(cpu_busy), 64'd0);
    chk("t5_state", 64'(dbg_rd_state), 64'(RD_IDLE));
    chk("t5_misroute", 64'(misroute_err), 64'd0);
    chk("t5_rdata", 64'(cpu_read_data), 64'd0);
    cpu_read = 0;
    tick();
    RESET = 0;
    tick();
    chk("t5_rx_ready", 64'(rx_ready), 64'd1);
    chk("t5_tx_count", 64'(dbg_tx_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
